// File: rtl/maze_pkg.sv
// Shared maze geometry, keycodes and probe FSM encoding for the Pac-Man collision blocks.
package maze_pkg;

  localparam int TILE_SHIFT = 3;
  localparam int MAP_W      = 51;
  localparam int MAP_H      = 56;
  localparam int ADDR_W     = 12;

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_UP    = 8'h1A;

  typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT, DONE} probe_state_t;

  // Corner index doubles as the bit position in the published flag vector.
  typedef enum logic [1:0] {C_TL, C_TR, C_BL, C_BR} corner_t;

endpackage

// File: rtl/frame_sync.sv
// Brings the slow frame strobe into the system clock domain and emits a one-cycle rising-edge pulse.
module frame_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [2:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[1:0], async_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/wall_probe.sv
// Per-frame wall probe: samples the player box, looks up the two leading corners in the wall ROM
// and publishes the four corner-blocked flags together once the sequence completes.
module wall_probe #(
  parameter int TILE_SHIFT  = maze_pkg::TILE_SHIFT,
  parameter int MAP_W       = maze_pkg::MAP_W,
  parameter int MAP_H       = maze_pkg::MAP_H,
  parameter int ADDR_W      = maze_pkg::ADDR_W,
  parameter int ROM_LATENCY = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_clk,
  input  logic [9:0]        BallX,
  input  logic [9:0]        BallY,
  input  logic [9:0]        BallS,
  input  logic [7:0]        keycode,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_data,
  output logic              mapTL,
  output logic              mapTR,
  output logic              mapBL,
  output logic              mapBR,
  output logic              probe_busy,
  output logic              overrun
);
  import maze_pkg::*;

  localparam logic signed [10:0] X_LIM = 11'(MAP_W << TILE_SHIFT);
  localparam logic signed [10:0] Y_LIM = 11'(MAP_H << TILE_SHIFT);

  typedef struct packed {
    logic              en;
    logic              oob;
    corner_t           corner;
    logic [ADDR_W-1:0] addr;
  } slot_t;

  function automatic slot_t mk_slot(input logic signed [10:0] px, input logic signed [10:0] py,
                                    input corner_t c);
    slot_t       r;
    logic [21:0] a;
    a        = 22'(py >> TILE_SHIFT) * 22'(MAP_W) + 22'(px >> TILE_SHIFT);
    r.en     = 1'b1;
    r.oob    = px[10] | py[10] | (px >= X_LIM) | (py >= Y_LIM);
    r.corner = c;
    r.addr   = a[ADDR_W-1:0];
    return r;
  endfunction

  logic frame_rise;

  frame_sync u_sync (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .async_in (frame_clk),
    .rise     (frame_rise)
  );

  probe_state_t      state_q, state_d;
  logic [1:0]        slot_idx_q, slot_idx_d;
  logic [1:0]        wcnt_q, wcnt_d;
  slot_t [1:0]       slots_q, slots_d, calc_slot;
  slot_t             nxt_slot, cur_slot;
  logic              has_dir, wait_last;
  logic signed [10:0] x, y, s;
  logic [3:0]        flags_q, flags_d, map_q, map_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              busy_q, overrun_q, overrun_d;

  // Slots 0/1 hold the two corners facing the move; slots 2/3 only burn time.
  always_comb begin
    x         = signed'({1'b0, BallX});
    y         = signed'({1'b0, BallY});
    s         = signed'({1'b0, BallS});
    calc_slot = '0;
    has_dir   = 1'b1;
    case (keycode)
      KEY_LEFT: begin
        calc_slot[0] = mk_slot(x - s - 11'sd1, y - s, C_TL);
        calc_slot[1] = mk_slot(x - s - 11'sd1, y + s, C_BL);
      end
      KEY_RIGHT: begin
        calc_slot[0] = mk_slot(x + s + 11'sd1, y - s, C_TR);
        calc_slot[1] = mk_slot(x + s + 11'sd1, y + s, C_BR);
      end
      KEY_UP: begin
        calc_slot[0] = mk_slot(x - s, y - s - 11'sd1, C_TL);
        calc_slot[1] = mk_slot(x + s, y - s - 11'sd1, C_TR);
      end
      KEY_DOWN: begin
        calc_slot[0] = mk_slot(x - s, y + s + 11'sd1, C_BL);
        calc_slot[1] = mk_slot(x + s, y + s + 11'sd1, C_BR);
      end
      default: has_dir = 1'b0;
    endcase
  end

  assign wait_last = (state_q == WAIT) && (wcnt_q == 2'(ROM_LATENCY - 1));
  assign cur_slot  = slot_idx_q[1] ? slot_t'('0) : slots_q[slot_idx_q[0]];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    slot_idx_d = slot_idx_q;
    wcnt_d     = wcnt_q;
    case (state_q)
      IDLE:  if (frame_rise) state_d = CALC;
      CALC: begin
        slot_idx_d = '0;
        state_d    = has_dir ? ISSUE : DONE;
      end
      ISSUE: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (!wait_last)               wcnt_d  = wcnt_q + 2'd1;
        else if (slot_idx_q == 2'd3)  state_d = DONE;
        else begin
          state_d    = ISSUE;
          slot_idx_d = slot_idx_q + 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The address register loads on entry to ISSUE, so the first probe is taken from the live CALC result.
  always_comb begin
    slots_d    = slots_q;
    flags_d    = flags_q;
    map_d      = map_q;
    rom_addr_d = rom_addr_q;
    nxt_slot   = '0;
    overrun_d  = overrun_q | (frame_rise & (state_q != IDLE));
    if (state_q == CALC) begin
      slots_d  = calc_slot;
      flags_d  = '0;
      nxt_slot = calc_slot[0];
    end else if (!slot_idx_d[1]) begin
      nxt_slot = slots_q[slot_idx_d[0]];
    end
    if (state_d == ISSUE && nxt_slot.en && !nxt_slot.oob) rom_addr_d = nxt_slot.addr;
    if (wait_last && cur_slot.en) flags_d[cur_slot.corner] = cur_slot.oob | rom_data;
    if (state_d == DONE) map_d = flags_d;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      slot_idx_q <= '0;
      wcnt_q     <= '0;
      slots_q    <= '0;
      flags_q    <= '0;
      map_q      <= '0;
      rom_addr_q <= '0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      slot_idx_q <= slot_idx_d;
      wcnt_q     <= wcnt_d;
      slots_q    <= slots_d;
      flags_q    <= flags_d;
      map_q      <= map_d;
      rom_addr_q <= rom_addr_d;
      busy_q     <= (state_d != IDLE);
      overrun_q  <= overrun_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign mapTL      = map_q[C_TL];
  assign mapTR      = map_q[C_TR];
  assign mapBL      = map_q[C_BL];
  assign mapBR      = map_q[C_BR];
  assign probe_busy = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_wall_probe.sv
// Scoreboarded bench for wall_probe: directed corner cases plus randomized frames against a tile-level model.
module tb_wall_probe;
  import maze_pkg::*;

  logic        Clk = 1'b0, Reset_n = 1'b0, frame_clk = 1'b0;
  logic [9:0]  BallX = '0, BallY = '0, BallS = '0;
  logic [7:0]  keycode = '0;
  logic [11:0] rom_addr;
  logic        rom_data = 1'b0;
  logic        mapTL, mapTR, mapBL, mapBR, probe_busy, overrun;
  logic [3:0]  flags_v;

  always #5 Clk = ~Clk;

  wall_probe #(.ROM_LATENCY(1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .BallX(BallX), .BallY(BallY), .BallS(BallS), .keycode(keycode),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .mapTL(mapTL), .mapTR(mapTR), .mapBL(mapBL), .mapBR(mapBR),
    .probe_busy(probe_busy), .overrun(overrun)
  );

  assign flags_v = {mapBR, mapBL, mapTR, mapTL};

  bit rom_mem [4096];
  always @(posedge Clk) rom_data <= rom_mem[rom_addr];

  typedef struct {
    logic [3:0]  flags;
    logic [11:0] addr;
    int          dur;
  } exp_t;

  exp_t        exp_q[$];
  int          n_chk = 0, n_pass = 0;
  logic [11:0] model_addr = '0;
  logic [11:0] tr_addr  [16];
  logic [3:0]  tr_flags [16];
  logic        tr_busy  [16];
  logic        tr_ovr   [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, want);
  endtask

  // Tile-level reference: named corners of the move, integer tile division, last in-bounds lookup drives the address.
  function automatic exp_t model(input int x, input int y, input int s, input logic [7:0] key,
                                 input logic [11:0] last);
    exp_t e;
    int px[2], py[2], ci[2], a;
    e.flags = '0; e.addr = last; e.dur = 10;
    case (key)
      KEY_LEFT:  begin px = '{x-s-1, x-s-1}; py = '{y-s, y+s};     ci = '{0, 2}; end
      KEY_RIGHT: begin px = '{x+s+1, x+s+1}; py = '{y-s, y+s};     ci = '{1, 3}; end
      KEY_UP:    begin px = '{x-s, x+s};     py = '{y-s-1, y-s-1}; ci = '{0, 1}; end
      KEY_DOWN:  begin px = '{x-s, x+s};     py = '{y+s+1, y+s+1}; ci = '{2, 3}; end
      default:   begin e.dur = 2; return e; end
    endcase
    for (int j = 0; j < 2; j++) begin
      if (px[j] < 0 || py[j] < 0 || px[j] >= 51*8 || py[j] >= 56*8) e.flags[ci[j]] = 1'b1;
      else begin
        a = (py[j] / 8) * 51 + px[j] / 8;
        e.flags[ci[j]] = rom_mem[a];
        e.addr = 12'(a);
      end
    end
    return e;
  endfunction

  task automatic do_frame(input int x, input int y, input int s, input logic [7:0] key, input bit dbl);
    exp_t e;
    @(negedge Clk);
    BallX = 10'(x); BallY = 10'(y); BallS = 10'(s); keycode = key;
    e = model(x, y, s, key, model_addr);
    model_addr = e.addr;
    exp_q.push_back(e);
    frame_clk = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(posedge Clk); @(negedge Clk);
      tr_addr[k] = rom_addr; tr_flags[k] = flags_v; tr_busy[k] = probe_busy; tr_ovr[k] = overrun;
      if (k == 4) frame_clk = 1'b0;
      if (dbl && k == 6) frame_clk = 1'b1;
      if (dbl && k == 9) frame_clk = 1'b0;
    end
  endtask

  // Monitor: every completed sequence (busy falling) is matched against the next queued expectation.
  bit prev_busy = 1'b0;
  int bcnt = 0;
  always @(negedge Clk) begin
    exp_t e;
    if (!Reset_n) begin
      prev_busy = 1'b0; bcnt = 0; exp_q.delete();
    end else begin
      if (probe_busy) bcnt++;
      else if (prev_busy) begin
        if (exp_q.size() == 0) chk("pending_exp", 32'(exp_q.size()), 32'd1);
        else begin
          e = exp_q.pop_front();
          chk("sb_flags", 32'(flags_v), 32'(e.flags));
          chk("sb_rom_addr", 32'(rom_addr), 32'(e.addr));
          chk("sb_busy_len", 32'(bcnt), 32'(e.dur));
        end
        bcnt = 0;
      end
      prev_busy = probe_busy;
    end
  end

  initial begin
    bit same;
    logic [7:0] keys [4];
    keys = '{KEY_LEFT, KEY_RIGHT, KEY_DOWN, KEY_UP};

    // Reset held while frame_clk toggles
    repeat (3) begin
      @(negedge Clk); frame_clk = 1'b1;
      repeat (3) @(negedge Clk);
      frame_clk = 1'b0;
    end
    chk("rst_flags", 32'(flags_v), 32'd0);
    chk("rst_busy", 32'(probe_busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    @(negedge Clk); Reset_n = 1'b1;
    repeat (5) @(negedge Clk);

    // Left, empty maze
    do_frame(202, 253, 13, KEY_LEFT, 1'b0);
    chk("left_addr_c3", 32'(tr_addr[3]), 32'd1553);
    chk("left_addr_c5", 32'(tr_addr[5]), 32'd1706);
    chk("left_busy_c1", 32'(tr_busy[1]), 32'd0);
    chk("left_busy_c2", 32'(tr_busy[2]), 32'd1);
    chk("left_busy_c11", 32'(tr_busy[11]), 32'd1);
    chk("left_busy_c12", 32'(tr_busy[12]), 32'd0);
    chk("left_flags_c11", 32'(tr_flags[11]), 32'd0);

    // Left with a wall under the bottom-left probe
    rom_mem[1706] = 1'b1;
    do_frame(202, 253, 13, KEY_LEFT, 1'b0);
    chk("wall_flags_c10", 32'(tr_flags[10]), 32'd0);
    chk("wall_flags_c11", 32'(tr_flags[11]), 32'b0100);

    // Left probes fall off the maze edge
    do_frame(10, 253, 13, KEY_LEFT, 1'b0);
    same = 1'b1;
    for (int k = 0; k < 16; k++) if (tr_addr[k] !== 12'd1706) same = 1'b0;
    chk("oob_addr_held", 32'(same), 32'd1);
    chk("oob_flags_c11", 32'(tr_flags[11]), 32'b0101);

    // No direction key
    do_frame(202, 253, 13, 8'h00, 1'b0);
    chk("nodir_flags_c2", 32'(tr_flags[2]), 32'b0101);
    chk("nodir_flags_c3", 32'(tr_flags[3]), 32'd0);
    chk("nodir_busy_c3", 32'(tr_busy[3]), 32'd1);
    chk("nodir_busy_c4", 32'(tr_busy[4]), 32'd0);
    chk("nodir_addr", 32'(tr_addr[15]), 32'd1706);

    // Randomized frames over randomized maze contents
    for (int i = 0; i < 30; i++) begin
      logic [7:0] key;
      for (int a = 0; a < 4096; a++) rom_mem[a] = ($urandom_range(0, 3) == 0);
      key = ($urandom_range(0, 4) == 4) ? 8'($urandom) : keys[$urandom_range(0, 3)];
      do_frame(int'($urandom_range(0, 470)), int'($urandom_range(0, 500)),
               int'($urandom_range(0, 40)), key, 1'b0);
    end

    // Second frame edge mid-sequence
    do_frame(10, 253, 13, KEY_LEFT, 1'b1);
    chk("ovr_before", 32'(tr_ovr[6]), 32'd0);
    chk("ovr_set", 32'(tr_ovr[15]), 32'd1);
    chk("ovr_flags", 32'(tr_flags[15]), 32'b0101);

    // Reset in the middle of a sequence
    @(negedge Clk);
    BallX = 10'd202; BallY = 10'd253; BallS = 10'd13; keycode = KEY_RIGHT;
    frame_clk = 1'b1;
    repeat (7) @(negedge Clk);
    frame_clk = 1'b0; Reset_n = 1'b0; model_addr = '0;
    #1;
    chk("midrst_overrun", 32'(overrun), 32'd0);
    chk("midrst_flags", 32'(flags_v), 32'd0);
    chk("midrst_busy", 32'(probe_busy), 32'd0);
    chk("midrst_rom_addr", 32'(rom_addr), 32'd0);
    @(negedge Clk); Reset_n = 1'b1;
    repeat (20) @(negedge Clk);
    chk("postrst_flags", 32'(flags_v), 32'd0);
    chk("postrst_busy", 32'(probe_busy), 32'd0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
